exec_alu_cc_stage: RTL and testbench
====================================

// Module: exec_alu_cc_stage
// PURPOSE
//  Registered execute stage of the Y86-64 SEQ core: selects ALU operands, computes
//  valE (the And64Bit/Add/Sub/Xor units combined under ifun), maintains the ZF/SF/OF
//  condition-code register and evaluates Cnd for jXX/cmovXX. Sits between decode and
//  memory; one-entry output register with valid/ready handshake; sticky halt.
// PARAMETERS
//  WIDTH     64      datapath width; all arithmetic is modulo 2^WIDTH
//  CC_RESET  3'b100  {ZF,SF,OF} value loaded on reset
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      decode presents an instruction
//  in_ready   out  1      stage accepts; = ~halted & (~out_valid | out_ready)
//  icode      in   4      Y86 instruction code
//  ifun       in   4      function code (ALU op or condition)
//  valA       in   WIDTH  decoded rA value
//  valB       in   WIDTH  decoded rB value
//  valC       in   WIDTH  immediate/displacement
//  out_valid  out  1      valE/cnd/icode_q valid for memory stage
//  out_ready  in   1      memory stage consumes this cycle
//  valE       out  WIDTH  registered ALU result
//  cnd        out  1      registered condition result
//  icode_q    out  4      registered icode
//  cc         out  3      current {ZF,SF,OF}
//  halted     out  1      sticky: halt or invalid icode accepted
// BEHAVIOUR
//  Reset (async, any time, incl. mid-transfer): out_valid=0, valE=0, cnd=0,
//   icode_q=0, halted=0, cc=CC_RESET. In-flight output is discarded.
//  Accept = in_valid & in_ready. On accept, next edge: out_valid=1, valE/cnd/icode_q load.
//  Latency 1 cycle. If out_valid & ~out_ready: all outputs and cc hold; in_ready=0.
//  If out_valid & out_ready & ~accept: out_valid->0 (valE keeps old value).
//  Accept and drain in the same cycle: back-to-back, full throughput.
//  valE by icode: 2 rrmov/cmov: valA; 3 irmovq: valC; 4/5 rm/mrmovq: valB+valC;
//   6 OPq: valB op valA, ifun 0 add,1 sub(valB-valA),2 and,3 xor, other ifun -> invalid;
//   8 call,A pushq: valB-8; 9 ret,B popq: valB+8; 0 halt,1 nop,7 jXX: 0.
//  icode > 4'hB or invalid OPq ifun: treated as halt (valE=0, cnd=0).
//  CC updates on the accepting edge only for valid OPq:
//   ZF=(res==0); SF=res[WIDTH-1];
//   add OF: a,b same sign & res sign differs; sub OF: valB,valA signs differ &
//   res sign != valB sign; and/xor OF=0. Carry out is dropped.
//  cnd (icode 2 or 7) uses cc BEFORE this instruction's update:
//   ifun 0 1; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne ~ZF; 5 ge ~(SF^OF);
//   6 g ~(SF^OF)&~ZF; ifun>6 -> invalid. Other icodes: cnd=0.
//  Halt (icode 0 or invalid) is passed downstream once, then halted=1,
//   in_ready=0 until reset; remaining output still drains normally.
//  cc never changes while output is stalled (no accept occurs).
// TESTING
//  OPq add: valA=64'h7FFF_FFFF_FFFF_FFFF, valB=1 -> valE=64'h8000_0000_0000_0000, cc=3'b011.
//  OPq sub: valA=5, valB=5 -> valE=0, cc=3'b100; next jXX ifun=3 -> cnd=1, ifun=4 -> cnd=0.
//  OPq and: valA=4, valB=3 -> valE=0, cc=3'b100; then valA=7,valB=3 -> valE=3, cc=3'b000.
//  pushq valB=64'h100 with out_ready=0 for 3 cycles -> valE=64'hF8 held, in_ready=0, cc unchanged.
//  icode=4'hC accepted -> out_valid 1 cycle with icode_q=C, then halted=1, in_ready=0.
//  rst pulsed mid-stall (async, between edges) -> out_valid=0, cc=3'b100 immediately.

Source files
------------

// File: rtl/exec_alu_cc_stage.sv
// Y86-64 execute stage: operand selection, ALU, {ZF,SF,OF} condition codes and
// Cnd evaluation, behind a one-entry valid/ready output register with sticky halt.
module exec_alu_cc_stage #(
    parameter int         WIDTH    = 64,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] valE,
    output logic             cnd,
    output logic [3:0]       icode_q,
    output logic [2:0]       cc,
    output logic             halted
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; the producer holds its payload stable while valid & ~ready.
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV  = 4'h3;
    localparam logic [3:0] I_RMMOV  = 4'h4;
    localparam logic [3:0] I_MRMOV  = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [WIDTH-1:0] STACK_STEP = WIDTH'(8);

    logic             zf, sf, of;
    logic             cond_true;
    logic             cond_valid;
    logic [WIDTH-1:0] res;
    logic             res_of;
    logic             cnd_c;
    logic             halt_c;
    logic             cc_we;
    logic             accept;

    assign zf = cc[2];
    assign sf = cc[1];
    assign of = cc[0];

    assign in_ready = ~halted & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    // Condition evaluation always looks at the flags as they stand before the
    // instruction being accepted updates them.
    always_comb begin
        cond_true  = 1'b0;
        cond_valid = 1'b1;
        case (ifun)
            4'd0:    cond_true = 1'b1;
            4'd1:    cond_true = (sf ^ of) | zf;
            4'd2:    cond_true = sf ^ of;
            4'd3:    cond_true = zf;
            4'd4:    cond_true = ~zf;
            4'd5:    cond_true = ~(sf ^ of);
            4'd6:    cond_true = ~(sf ^ of) & ~zf;
            default: cond_valid = 1'b0;
        endcase
    end

    always_comb begin
        res    = '0;
        res_of = 1'b0;
        cnd_c  = 1'b0;
        halt_c = 1'b0;
        cc_we  = 1'b0;
        case (icode)
            I_HALT: halt_c = 1'b1;
            I_NOP:  res = '0;
            I_RRMOV: begin
                if (cond_valid) begin
                    res   = valA;
                    cnd_c = cond_true;
                end else begin
                    halt_c = 1'b1;
                end
            end
            I_IRMOV:          res = valC;
            I_RMMOV, I_MRMOV: res = valB + valC;
            I_OPQ: begin
                cc_we = 1'b1;
                case (ifun)
                    4'd0: begin
                        res    = valB + valA;
                        res_of = (valA[WIDTH-1] == valB[WIDTH-1]) &&
                                 (res[WIDTH-1] != valB[WIDTH-1]);
                    end
                    4'd1: begin
                        res    = valB - valA;
                        res_of = (valA[WIDTH-1] != valB[WIDTH-1]) &&
                                 (res[WIDTH-1] != valB[WIDTH-1]);
                    end
                    4'd2:    res = valB & valA;
                    4'd3:    res = valB ^ valA;
                    default: begin
                        cc_we  = 1'b0;
                        halt_c = 1'b1;
                    end
                endcase
            end
            I_JXX: begin
                if (cond_valid) cnd_c = cond_true;
                else            halt_c = 1'b1;
            end
            I_CALL, I_PUSHQ: res = valB - STACK_STEP;
            I_RET,  I_POPQ:  res = valB + STACK_STEP;
            default:         halt_c = 1'b1;
        endcase
        // Anything treated as halt reaches memory as a zero-result, no-condition op.
        if (halt_c) begin
            res   = '0;
            cnd_c = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            valE      <= '0;
            cnd       <= 1'b0;
            icode_q   <= '0;
            cc        <= CC_RESET;
            halted    <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            valE      <= res;
            cnd       <= cnd_c;
            icode_q   <= icode;
            if (cc_we) cc <= {(res == '0), res[WIDTH-1], res_of};
            // The halting op itself still goes downstream; nothing after it is taken.
            if (halt_c) halted <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exec_alu_cc_stage.sv
// Randomised scoreboard bench for exec_alu_cc_stage with directed corner cases
// (overflow, zero flags, conditions, stalls, halt and asynchronous reset).
module tb_exec_alu_cc_stage;

    typedef struct packed {
        logic [3:0]  icode;
        logic [63:0] val_e;
        logic        cnd;
        logic [2:0]  cc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  icode = '0;
    logic [3:0]  ifun = '0;
    logic [63:0] val_a = '0;
    logic [63:0] val_b = '0;
    logic [63:0] val_c = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] val_e;
    logic        cnd;
    logic [3:0]  icode_q;
    logic [2:0]  cc;
    logic        halted;

    exp_t        exp_q[$];
    logic [2:0]  model_cc = 3'b100;
    logic        model_halted = 1'b0;
    int          rdy_mode = 1;  // 0 random, 1 always ready, 2 never ready
    int          n_checks = 0;
    int          n_pass = 0;

    exec_alu_cc_stage #(.WIDTH(64), .CC_RESET(3'b100)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun), .valA(val_a), .valB(val_b), .valC(val_c),
        .out_valid(out_valid), .out_ready(out_ready), .valE(val_e), .cnd(cnd),
        .icode_q(icode_q), .cc(cc), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: Y86 execute semantics in plain arithmetic. Overflow is
    // judged by whether the exact signed result fits in 64 bits.
    task automatic model(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [2:0] cc_in, output exp_t e,
                         output logic [2:0] cc_out, output logic h);
        logic zf, sf, ovf, lt, cond, cond_ok;
        logic [63:0] r;
        logic signed [64:0] exact;
        zf = cc_in[2]; sf = cc_in[1]; ovf = cc_in[0];
        lt = (sf != ovf);
        cond_ok = (fn <= 4'd6);
        case (fn)
            4'd0: cond = 1'b1;
            4'd1: cond = lt || zf;
            4'd2: cond = lt;
            4'd3: cond = zf;
            4'd4: cond = !zf;
            4'd5: cond = !lt;
            4'd6: cond = !lt && !zf;
            default: cond = 1'b0;
        endcase
        cc_out = cc_in;
        h = 1'b0;
        e.icode = ic;
        e.val_e = 64'd0;
        e.cnd = 1'b0;
        case (ic)
            4'h0: h = 1'b1;
            4'h1: ;
            4'h2: if (cond_ok) begin e.val_e = a; e.cnd = cond; end else h = 1'b1;
            4'h3: e.val_e = c;
            4'h4, 4'h5: e.val_e = b + c;
            4'h6: begin
                if (fn > 4'd3) h = 1'b1;
                else begin
                    exact = 65'sd0;
                    case (fn)
                        4'd0: begin r = b + a; exact = $signed({b[63], b}) + $signed({a[63], a}); end
                        4'd1: begin r = b - a; exact = $signed({b[63], b}) - $signed({a[63], a}); end
                        4'd2: r = b & a;
                        default: r = b ^ a;
                    endcase
                    if (fn <= 4'd1) ovf = (exact != $signed({r[63], r}));
                    else ovf = 1'b0;
                    e.val_e = r;
                    cc_out = {(r == 64'd0), r[63], ovf};
                end
            end
            4'h7: if (cond_ok) e.cnd = cond; else h = 1'b1;
            4'h8, 4'hA: e.val_e = b - 64'd8;
            4'h9, 4'hB: e.val_e = b + 64'd8;
            default: h = 1'b1;
        endcase
        e.cc = cc_out;
    endtask

    always @(negedge clk) begin
        case (rdy_mode)
            0: out_ready = ($urandom_range(0, 3) != 0);
            1: out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        exp_t e;
        logic [2:0] ncc;
        logic h;
        int waited = 0;
        logic done = 1'b0;
        in_valid = 1'b1; icode = ic; ifun = fn; val_a = a; val_b = b; val_c = c;
        while (!done) begin
            #1;
            if (in_ready) begin
                model(ic, fn, a, b, c, model_cc, e, ncc, h);
                exp_q.push_back(e);
                model_cc = ncc;
                model_halted = h;
                done = 1'b1;
            end
            @(negedge clk);
            waited++;
            if (!done && waited > 100) begin
                chk("accept_timeout", 64'd0, 64'd1);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        rdy_mode = 1;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        exp_q.delete();
        model_cc = 3'b100;
        model_halted = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            4: return 64'($urandom_range(0, 16));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: compares each transfer to memory against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("icode_q", 64'(icode_q), 64'(e.icode));
                    chk("valE", val_e, e.val_e);
                    chk("cnd", 64'(cnd), 64'(e.cnd));
                    chk("cc", 64'(cc), 64'(e.cc));
                end
            end
        end
    end

    initial begin
        logic [2:0] cc_before;
        logic [3:0] ic, fn;

        @(negedge clk);
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_valE", val_e, 64'd0);
        chk("rst_cnd", 64'(cnd), 64'd0);
        chk("rst_icode_q", 64'(icode_q), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_cc", 64'(cc), 64'd4);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        issue(4'h6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        drain();
        chk("add_ovf_cc", 64'(cc), 64'(3'b011));

        issue(4'h6, 4'd1, 64'd5, 64'd5, 64'd0);
        issue(4'h7, 4'd3, 64'd0, 64'd0, 64'h40);
        issue(4'h7, 4'd4, 64'd0, 64'd0, 64'h40);
        drain();
        chk("sub_zero_cc", 64'(cc), 64'(3'b100));

        issue(4'h6, 4'd2, 64'd4, 64'd3, 64'd0);
        drain();
        chk("and_zero_cc", 64'(cc), 64'(3'b100));
        issue(4'h6, 4'd2, 64'd7, 64'd3, 64'd0);
        drain();
        chk("and_nz_cc", 64'(cc), 64'(3'b000));

        // pushq held by a stalled consumer
        rdy_mode = 2;
        out_ready = 1'b0;
        cc_before = model_cc;
        issue(4'hA, 4'd0, 64'h1234, 64'h100, 64'h55);
        repeat (3) begin
            #2;
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_valE", val_e, 64'hF8);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_cc", 64'(cc), 64'(cc_before));
            @(negedge clk);
        end
        drain();

        // asynchronous reset between edges while stalled
        rdy_mode = 2;
        out_ready = 1'b0;
        issue(4'h6, 4'd0, 64'd1, 64'd2, 64'd0);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_cc", 64'(cc), 64'(3'b100));
        rst = 1'b0;
        exp_q.delete();
        model_cc = 3'b100;
        model_halted = 1'b0;
        rdy_mode = 1;
        @(negedge clk);

        // invalid icode behaves as halt
        issue(4'hC, 4'd0, 64'd9, 64'd9, 64'd9);
        drain();
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_in_ready", 64'(in_ready), 64'd0);
        chk("halt_out_valid", 64'(out_valid), 64'd0);
        repeat (3) @(negedge clk);
        chk("halt_sticky", 64'(in_ready), 64'd0);
        do_reset();

        rdy_mode = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) ic = 4'($urandom_range(0, 15));
            else ic = 4'($urandom_range(1, 11));
            if (ic == 4'h6) fn = 4'($urandom_range(0, 3));
            else if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 6));
            else fn = 4'd0;
            if ($urandom_range(0, 19) == 0) fn = 4'($urandom_range(0, 15));
            issue(ic, fn, rnd64(), rnd64(), rnd64());
            if (model_halted) begin
                drain();
                chk("rand_halted", 64'(halted), 64'd1);
                chk("rand_halt_in_ready", 64'(in_ready), 64'd0);
                do_reset();
                rdy_mode = 0;
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
